// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic-array front end: FSM states,
// default operand width / array dimension and the skew counter width helper.
package systolic_pkg;

  localparam int unsigned DEF_BITS_AB = 8;
  localparam int unsigned DEF_DIM     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One operation spans 3*DIM-2 advances; the counter must hold that value.
  function automatic int unsigned cnt_width(input int unsigned dim);
    return $clog2(3 * dim);
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane delay chain: DEPTH registers that shift only when en is high.
// The last stage drives dout.
module skew_lane
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned DEPTH   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [BITS_AB-1:0] din,
  output logic [BITS_AB-1:0] dout
);

  logic [DEPTH-1:0][BITS_AB-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else if (en) begin
      stage[0] <= din;
      for (int k = 1; k < int'(DEPTH); k++) begin
        stage[k] <= stage[k-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// Skews A columns / B rows into a DIM x DIM systolic array: lane i is delayed
// by i advances, then zeros are flushed through the wavefront before done.
// Optional SKEW_FEEDER_STALL_CNT_EN adds a saturating 16-bit LOAD stall counter.
module skew_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned BITS_AB = DEF_BITS_AB,
  parameter int unsigned DIM     = DEF_DIM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIM-1:0][BITS_AB-1:0] A_in,
  input  logic [DIM-1:0][BITS_AB-1:0] B_in,
  output logic [DIM-1:0][BITS_AB-1:0] A_out,
  output logic [DIM-1:0][BITS_AB-1:0] B_out,
  output logic                        mac_en,
  output logic                        done
`ifdef SKEW_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int unsigned CW = cnt_width(DIM);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          advance;

  assign accept  = in_valid && in_ready;
  assign advance = accept || (state == DRAIN);

  // cnt tracks advances taken in the current operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      in_ready <= 1'b0;
      mac_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      mac_en   <= advance;
      done     <= 1'b0;
      in_ready <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= LOAD;
            cnt   <= CW'(1);
          end
        end
        LOAD: begin
          if (accept) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(DIM - 1)) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          cnt      <= cnt + CW'(1);
          in_ready <= 1'b0;
          if (cnt == CW'(3 * DIM - 3)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lanes carry two's-complement data untouched; DRAIN pushes zeros in.
  for (genvar i = 0; i < int'(DIM); i++) begin : g_lane
    logic [BITS_AB-1:0] a_head;
    logic [BITS_AB-1:0] b_head;

    assign a_head = (state == DRAIN) ? '0 : A_in[i];
    assign b_head = (state == DRAIN) ? '0 : B_in[i];

    skew_lane #(.BITS_AB(BITS_AB), .DEPTH(i + 1)) u_a (
      .clk  (clk),
      .rst  (rst),
      .en   (advance),
      .din  (a_head),
      .dout (A_out[i])
    );

    skew_lane #(.BITS_AB(BITS_AB), .DEPTH(i + 1)) u_b (
      .clk  (clk),
      .rst  (rst),
      .en   (advance),
      .din  (b_head),
      .dout (B_out[i])
    );
  end

`ifdef SKEW_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == IDLE && accept) begin
      stall_cnt <= '0;
    end else if (state == LOAD && !in_valid && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_skew_feeder.sv
// Bench for skew_feeder (DIM=8, BITS_AB=8): random operand beats checked against
// a wavefront model; covers stalls, signed data, reset mid-drain, back-pressure.
module tb_skew_feeder;

  localparam int DIM = 8;
  localparam int W   = 8;

  typedef logic [DIM-1:0][W-1:0] vec_t;
  typedef struct packed {
    logic rdy;
    logic mac;
    logic dn;
    vec_t a;
    vec_t b;
  } samp_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  vec_t a_in, b_in, a_out, b_out;
  logic mac_en;
  logic done;
`ifdef SKEW_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  skew_feeder #(.BITS_AB(W), .DIM(DIM)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A_in     (a_in),
    .B_in     (b_in),
    .A_out    (a_out),
    .B_out    (b_out),
    .mac_en   (mac_en),
    .done     (done)
`ifdef SKEW_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  int tests;
  int fails;
  logic [W-1:0] beat_a[DIM][DIM];  // [beat k][lane]
  logic [W-1:0] beat_b[DIM][DIM];
  samp_t rec[$];                   // rec[j] is cycle j+1 of the run
  int first_acc, last_acc;

  // Model: after n advances, lane i shows beat n-1-i, or zero outside the operand window.
  function automatic vec_t exp_vec(input int n, input bit is_b);
    vec_t v;
    for (int i = 0; i < DIM; i++) begin
      int idx;
      idx = n - 1 - i;
      if (idx >= 0 && idx < DIM) v[i] = is_b ? beat_b[idx][i] : beat_a[idx][i];
      else v[i] = '0;
    end
    return v;
  endfunction

  task automatic fill_beats(input int mode);
    for (int k = 0; k < DIM; k++) begin
      for (int i = 0; i < DIM; i++) begin
        beat_a[k][i] = (mode == 1) ? W'(10 * k + i) : W'($urandom);
        beat_b[k][i] = (mode == 2) ? 8'h80 : W'($urandom);
      end
    end
  endtask

  // Drives one operation and records every cycle; stops the cycle after done,
  // or asserts rst on drain cycle rst_drain when that is non-zero.
  task automatic run_op(input int stall_at, input int stall_len, input bit hold, input int rst_drain);
    int k, cyc, sl;
    bit seen_done, stop;
    samp_t s;
    k = 0; cyc = 0; sl = stall_len; seen_done = 0; stop = 0;
    rec.delete();
    first_acc = -1;
    last_acc  = -1;
    while (!stop && cyc < 120) begin
      @(negedge clk);
      cyc++;
      s.rdy = in_ready; s.mac = mac_en; s.dn = done; s.a = a_out; s.b = b_out;
      rec.push_back(s);
      if (seen_done) stop = 1;
      if (s.dn) seen_done = 1;
      if (rst_drain > 0 && k == DIM && cyc == last_acc + rst_drain) begin
        rst = 1'b1;
        break;
      end
      if (k < DIM) begin
        if (k == stall_at && sl > 0) begin
          in_valid = 1'b0;
          sl--;
        end else begin
          in_valid = 1'b1;
          for (int i = 0; i < DIM; i++) begin
            a_in[i] = beat_a[k][i];
            b_in[i] = beat_b[k][i];
          end
        end
      end else begin
        in_valid = hold;
        for (int i = 0; i < DIM; i++) begin
          a_in[i] = W'($urandom);
          b_in[i] = W'($urandom);
        end
      end
      if (in_valid && s.rdy && k < DIM) begin
        if (k == 0) first_acc = cyc;
        last_acc = cyc;
        k++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (in_ready !== 1'b0 || mac_en !== 1'b0 || done !== 1'b0 || a_out !== '0 || b_out !== '0) begin
      fails++;
      $display("FAIL reset_state in_ready=%b mac_en=%b done=%b A_out=%h B_out=%h required all zero",
               in_ready, mac_en, done, a_out, b_out);
    end
`ifdef SKEW_FEEDER_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_stall_cnt got %0d required 0", stall_cnt);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_after got %b required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int n, dcnt, dcyc;
    fill_beats(1);
    run_op(-1, 0, 1'b0, 0);
    n = 0; dcnt = 0; dcyc = -1;
    foreach (rec[j]) begin
      if (rec[j].mac) begin
        n++;
        if (n >= 4 && n <= 11) begin
          tests++;
          if (rec[j].a[3] !== W'(10 * (n - 4) + 3)) begin
            fails++;
            $display("FAIL b2b_lane3 mac=%0d A_out[3]=%0d required %0d", n, rec[j].a[3], 10 * (n - 4) + 3);
          end
        end
      end
      if (rec[j].dn) begin dcnt++; dcyc = j + 1; end
      tests++;
      if (rec[j].a !== exp_vec(n, 0) || rec[j].b !== exp_vec(n, 1)) begin
        fails++;
        $display("FAIL b2b_data cyc=%0d A_out=%h B_out=%h required A=%h B=%h",
                 j + 1, rec[j].a, rec[j].b, exp_vec(n, 0), exp_vec(n, 1));
      end
    end
    tests++;
    if (n !== 3 * DIM - 2 || last_acc - first_acc !== DIM - 1) begin
      fails++;
      $display("FAIL b2b_count mac_cycles=%0d beat_span=%0d required %0d and %0d", n, last_acc - first_acc, 3 * DIM - 2, DIM - 1);
    end
    tests++;
    if (dcnt !== 1 || dcyc !== last_acc + 15) begin
      fails++;
      $display("FAIL b2b_done pulses=%0d at=%0d required 1 at %0d", dcnt, dcyc, last_acc + 15);
    end
  endtask

  task automatic test_stall();
    int n, gaps, first_mac, last_mac, dcyc;
    fill_beats(0);
    run_op(5, 3, 1'b0, 0);
    n = 0; first_mac = -1; last_mac = -1; dcyc = -1;
    foreach (rec[j]) begin
      if (rec[j].mac) begin
        n++;
        if (first_mac < 0) first_mac = j;
        last_mac = j;
      end
      if (rec[j].dn) dcyc = j + 1;
      tests++;
      if (rec[j].a !== exp_vec(n, 0) || rec[j].b !== exp_vec(n, 1)) begin
        fails++;
        $display("FAIL stall_data cyc=%0d A_out=%h B_out=%h required A=%h B=%h",
                 j + 1, rec[j].a, rec[j].b, exp_vec(n, 0), exp_vec(n, 1));
      end
    end
    gaps = (last_mac - first_mac + 1) - n;
    tests++;
    if (n !== 22 || gaps !== 3) begin
      fails++;
      $display("FAIL stall_mac mac_cycles=%0d gaps=%0d required 22 and 3", n, gaps);
    end
    tests++;
    if (dcyc !== last_acc + 15) begin
      fails++;
      $display("FAIL stall_done at=%0d required %0d", dcyc, last_acc + 15);
    end
`ifdef SKEW_FEEDER_STALL_CNT_EN
    tests++;
    if (stall_cnt !== 16'd3) begin
      fails++;
      $display("FAIL stall_cnt got %0d required 3", stall_cnt);
    end
`endif
  endtask

  task automatic test_signed();
    int n;
    fill_beats(2);
    run_op(-1, 0, 1'b0, 0);
    n = 0;
    foreach (rec[j]) begin
      if (rec[j].mac) begin
        n++;
        if (n >= 8) begin
          tests++;
          if (rec[j].b[7] !== ((n <= 15) ? 8'h80 : 8'h00)) begin
            fails++;
            $display("FAIL signed_b7 mac=%0d B_out[7]=%h required %h", n, rec[j].b[7], (n <= 15) ? 8'h80 : 8'h00);
          end
        end
      end
      tests++;
      if (rec[j].a !== exp_vec(n, 0) || rec[j].b !== exp_vec(n, 1)) begin
        fails++;
        $display("FAIL signed_data cyc=%0d A_out=%h B_out=%h required A=%h B=%h",
                 j + 1, rec[j].a, rec[j].b, exp_vec(n, 0), exp_vec(n, 1));
      end
    end
    tests++;
    if (n !== 22) begin
      fails++;
      $display("FAIL signed_count mac_cycles=%0d required 22", n);
    end
  endtask

  task automatic test_reset_mid_drain();
    int n, dseen, dcnt;
    fill_beats(0);
    run_op(-1, 0, 1'b0, 5);
    #1;
    tests++;
    if (a_out !== '0 || b_out !== '0 || mac_en !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_drain_outputs A_out=%h B_out=%h mac_en=%b done=%b in_ready=%b required all zero",
               a_out, b_out, mac_en, done, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    dseen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dseen++;
    end
    tests++;
    if (dseen !== 0) begin
      fails++;
      $display("FAIL rst_drain_no_done pulses=%0d required 0", dseen);
    end
    fill_beats(0);
    run_op(-1, 0, 1'b0, 0);
    n = 0; dcnt = 0;
    foreach (rec[j]) begin
      if (rec[j].mac) n++;
      if (rec[j].dn) dcnt++;
      tests++;
      if (rec[j].a !== exp_vec(n, 0) || rec[j].b !== exp_vec(n, 1)) begin
        fails++;
        $display("FAIL rst_drain_next_op cyc=%0d A_out=%h B_out=%h required A=%h B=%h",
                 j + 1, rec[j].a, rec[j].b, exp_vec(n, 0), exp_vec(n, 1));
      end
    end
    tests++;
    if (n !== 22 || dcnt !== 1) begin
      fails++;
      $display("FAIL rst_drain_next_count mac_cycles=%0d done_pulses=%0d required 22 and 1", n, dcnt);
    end
  endtask

  task automatic test_backpressure();
    int n, low;
    vec_t nxt_a, nxt_b;
    fill_beats(0);
    run_op(-1, 0, 1'b1, 0);
    n = 0; low = 0;
    foreach (rec[j]) begin
      if (rec[j].mac) n++;
      if (j >= last_acc && !rec[j].rdy) low++;
      tests++;
      if (rec[j].a !== exp_vec(n, 0) || rec[j].b !== exp_vec(n, 1)) begin
        fails++;
        $display("FAIL bp_data cyc=%0d A_out=%h B_out=%h required A=%h B=%h",
                 j + 1, rec[j].a, rec[j].b, exp_vec(n, 0), exp_vec(n, 1));
      end
    end
    tests++;
    if (low !== 15 || rec[rec.size() - 1].rdy !== 1'b1 || n !== 22) begin
      fails++;
      $display("FAIL bp_ready low_cycles=%0d ready_after_done=%b mac_cycles=%0d required 15, 1, 22",
               low, rec[rec.size() - 1].rdy, n);
    end
    nxt_a = a_in;
    nxt_b = b_in;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (mac_en !== 1'b1 || a_out[0] !== nxt_a[0] || b_out[0] !== nxt_b[0]) begin
      fails++;
      $display("FAIL bp_next_accept mac_en=%b A_out[0]=%h B_out[0]=%h required 1 %h %h",
               mac_en, a_out[0], b_out[0], nxt_a[0], nxt_b[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_signed();
    test_reset_mid_drain();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/skew_feeder.md
SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, operand element width (signed).
REQ-002 SHALL have parameter DIM, default 8, array dimension / lane count.
REQ-003 SHALL have port clk  in  1  single clock, all state rising-edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  in  1  input beat offered.
REQ-006 SHALL have port in_ready  out  1  beat accepted when in_valid&&in_ready.
REQ-007 SHALL have port A_in  in  DIM x BITS_AB signed  column k of A (lane i = A[i][k]).
REQ-008 SHALL have port B_in  in  DIM x BITS_AB signed  row k of B (lane j = B[k][j]).
REQ-009 SHALL have port A_out  out  DIM x BITS_AB signed  skewed A to array row inputs.
REQ-010 SHALL have port B_out  out  DIM x BITS_AB signed  skewed B to array column inputs.
REQ-011 SHALL have port mac_en  out  1  array enable, high only on cycles the outputs advance.
REQ-012 SHALL have port done  out  1  one-cycle pulse, product complete in array.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, DRAIN, DONE; reset state IDLE.
REQ-014 SHALL assert in_ready in IDLE and LOAD only; deassert in DRAIN and DONE.
REQ-015 SHALL go IDLE->LOAD on first accepted beat, which counts as beat 0.
REQ-016 SHALL accept exactly DIM beats per operation; LOAD->DRAIN on acceptance of beat DIM-1.
REQ-017 SHALL define "advance" = beat accepted (IDLE/LOAD) or any DRAIN cycle.
REQ-018 SHALL delay lane i (A and B) by i advances via a per-lane shift chain of i+1 registers, last stage driving the output; chains shift only on advance.
REQ-019 SHALL hold all chains, and drive mac_en=0, on cycles without advance (stall when in_valid low in LOAD).
REQ-020 SHALL inject zero into all lane chain heads on DRAIN advances.
REQ-021 SHALL register mac_en as the advance of the previous cycle (outputs and mac_en aligned, latency 1 cycle for lane 0).
REQ-022 SHALL remain in DRAIN for exactly 2*DIM-2 cycles, then enter DONE for one cycle asserting done, then IDLE.
REQ-023 SHALL produce exactly 3*DIM-2 mac_en-high cycles per operation, matching the array's full wavefront.
REQ-024 SHALL ignore in_valid in DRAIN/DONE; a beat offered there waits and is accepted on return to IDLE.
REQ-025 SHALL use a cycle counter of width $clog2(3*DIM), reset to 0 on each operation start.
REQ-026 SHALL pass data bits unmodified (no arithmetic, no width change).

Reset
REQ-027 SHALL on rst, asynchronously: FSM=IDLE, counter=0, all chain registers=0, A_out=B_out=0, mac_en=0, done=0, in_ready=0 while rst high, 1 on first cycle after.
REQ-028 SHALL abandon any operation when rst asserts mid-LOAD or mid-DRAIN, with no done pulse.

Configuration
REQ-029 SHALL, with macro SKEW_FEEDER_STALL_CNT_EN defined, add output stall_cnt (16 bits): counts LOAD cycles with in_valid low, cleared on operation start and on rst, saturating at 16'hFFFF.
REQ-030 SHALL, without SKEW_FEEDER_STALL_CNT_EN, omit the stall_cnt port and its logic; all other behaviour is identical.

Structure
REQ-031 SHALL place the FSM state enum typedef and default BITS_AB/DIM constants in shared package systolic_pkg.
REQ-032 SHALL implement one lane delay chain as sub-module skew_lane (parameters BITS_AB, DEPTH), instantiated 2*DIM times.

Verification (DIM=8, BITS_AB=8)
REQ-033 SHALL verify back-to-back: 8 beats with in_valid held high, A_in lane i = 10*k+i -> A_out[3] = 3,13,...,73 on mac_en cycles 4..11; 22 mac_en cycles total; done 15 cycles after last beat accepted.
REQ-034 SHALL verify stall: in_valid low for 3 cycles after beat 4 -> mac_en low for exactly 3 cycles, outputs held, totals unchanged (22 mac_en cycles).
REQ-035 SHALL verify signed passthrough: B_in all lanes = -128 (8'h80) for all beats -> B_out[7] = -128 on mac_en cycles 8..15, 0 on cycles 16..22.
REQ-036 SHALL verify reset mid-DRAIN: rst pulsed on drain cycle 5 -> all outputs 0 immediately, no done, next operation correct from beat 0.
REQ-037 SHALL verify back-pressure: in_valid held high through DRAIN -> in_ready=0 for 15 cycles, next beat accepted in the cycle after done.
REQ-038 SHALL verify, with SKEW_FEEDER_STALL_CNT_EN, that scenario REQ-034 yields stall_cnt = 3.
